ysyx_210238_pipeline_ctrl: RTL and testbench

YSYX_210238_PIPELINE_CTRL -- requirements
Module: ysyx_210238_pipeline_ctrl

---
 rtl/ysyx_210238_pkg.sv | 45 ++++
 rtl/ysyx_210238_hazard_detect.sv | 24 ++
 rtl/ysyx_210238_pipeline_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ysyx_210238_pipeline_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_210238_pkg.sv
// Shared defines for the ysyx_210238 pipeline control slice.
//   state_e : pipeline-control FSM states (RUN / DRAIN)
//   cause_e : stall/flush causes in the order they are ranked
//   pick_cause : returns the highest-ranked active cause
package ysyx_210238_pkg;

    // DRAIN: one stale fetch response is still owed by the fetch unit.
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    // Lower numeric value = higher priority (CAUSE_NONE aside).
    typedef enum logic [2:0] {
        CAUSE_NONE       = 3'd0,
        CAUSE_TRAP       = 3'd1,
        CAUSE_MEM_BUSY   = 3'd2,
        CAUSE_EX_BUSY    = 3'd3,
        CAUSE_REDIRECT   = 3'd4,
        CAUSE_LOAD_USE   = 3'd5,
        CAUSE_FETCH_WAIT = 3'd6
    } cause_e;

    localparam int unsigned STALL_CNT_W = 32;

    function automatic cause_e pick_cause(
        input logic trap,
        input logic mem_busy,
        input logic ex_busy,
        input logic redirect,
        input logic load_use,
        input logic fetch_wait
    );
        cause_e c;
        if (trap)            c = CAUSE_TRAP;
        else if (mem_busy)   c = CAUSE_MEM_BUSY;
        else if (ex_busy)    c = CAUSE_EX_BUSY;
        else if (redirect)   c = CAUSE_REDIRECT;
        else if (load_use)   c = CAUSE_LOAD_USE;
        else if (fetch_wait) c = CAUSE_FETCH_WAIT;
        else                 c = CAUSE_NONE;
        return c;
    endfunction

endpackage

// File: rtl/ysyx_210238_hazard_detect.sv
// Load-use hazard detection (purely combinational).
//   i_id_rs1/i_id_rs2       : ID-stage source register indices
//   i_id_rs1_en/i_id_rs2_en : source register use flags
//   i_ex_rd, i_ex_load      : EX-stage destination and load flag
//   o_load_use              : ID consumes the result of the load in EX
module ysyx_210238_hazard_detect (
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_rs1_en,
    input  logic       i_id_rs2_en,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_load,
    output logic       o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit  = i_id_rs1_en && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit  = i_id_rs2_en && (i_id_rs2 == i_ex_rd);
    // x0 is never a real dependency.
    assign o_load_use = i_ex_load && (i_ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/ysyx_210238_pipeline_ctrl.sv
// Pipeline hold/clear/redirect control for a 5-stage core.
//   clk, rst                 : clock, synchronous active-high reset
//   id_*, ex_rd, ex_load     : operands for load-use detection
//   ex_busy, mem_busy        : multi-cycle EX op / incomplete data access
//   if_busy, if_rsp_valid    : fetch outstanding / fetch response this cycle
//   ex_redirect, ex_target   : branch/jump redirect from EX
//   mem_trap, trap_vec       : trap from MEM and its vector
//   pc_hold/pc_load/pc_next  : PC control
//   <stage>_hold/<stage>_clear : pipeline register control
//   if_rsp_drop              : discard current fetch response
//   stall_cnt                : count of cycles with pc_hold=1 (wraps)
module ysyx_210238_pipeline_ctrl
    import ysyx_210238_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic                   id_rs1_en,
    input  logic                   id_rs2_en,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_load,
    input  logic                   ex_busy,
    input  logic                   mem_busy,
    input  logic                   if_busy,
    input  logic                   if_rsp_valid,
    input  logic                   ex_redirect,
    input  logic [XLEN-1:0]        ex_target,
    input  logic                   mem_trap,
    input  logic [XLEN-1:0]        trap_vec,
    output logic                   pc_hold,
    output logic                   pc_load,
    output logic [XLEN-1:0]        pc_next,
    output logic                   if_id_hold,
    output logic                   if_id_clear,
    output logic                   id_ex_hold,
    output logic                   id_ex_clear,
    output logic                   ex_mem_hold,
    output logic                   ex_mem_clear,
    output logic                   mem_wb_hold,
    output logic                   mem_wb_clear,
    output logic                   if_rsp_drop,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    state_e                 r_state;
    state_e                 w_next_state;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic                   w_load_use;
    logic                   w_trap;
    logic                   w_fetch_wait;
    logic                   w_flush;
    cause_e                 w_cause;

    ysyx_210238_hazard_detect u_hazard (
        .i_id_rs1    (id_rs1),
        .i_id_rs2    (id_rs2),
        .i_id_rs1_en (id_rs1_en),
        .i_id_rs2_en (id_rs2_en),
        .i_ex_rd     (ex_rd),
        .i_ex_load   (ex_load),
        .o_load_use  (w_load_use)
    );

    // A trap is only meaningful once the data access has completed.
    assign w_trap       = mem_trap && !mem_busy;
    assign w_fetch_wait = (if_busy && !if_rsp_valid) || (r_state == ST_DRAIN);
    assign w_cause      = pick_cause(w_trap, mem_busy, ex_busy, ex_redirect,
                                     w_load_use, w_fetch_wait);
    assign w_flush      = (w_cause == CAUSE_TRAP) || (w_cause == CAUSE_REDIRECT);

    always_comb begin
        pc_hold      = 1'b0;
        pc_load      = 1'b0;
        pc_next      = '0;
        if_id_hold   = 1'b0;
        if_id_clear  = 1'b0;
        id_ex_hold   = 1'b0;
        id_ex_clear  = 1'b0;
        ex_mem_hold  = 1'b0;
        ex_mem_clear = 1'b0;
        mem_wb_hold  = 1'b0;
        mem_wb_clear = 1'b0;
        if_rsp_drop  = 1'b0;
        w_next_state = r_state;

        if (rst) begin
            if_id_clear  = 1'b1;
            id_ex_clear  = 1'b1;
            ex_mem_clear = 1'b1;
            mem_wb_clear = 1'b1;
            w_next_state = ST_RUN;
        end else begin
            unique case (w_cause)
                CAUSE_TRAP: begin
                    pc_load      = 1'b1;
                    pc_next      = trap_vec;
                    if_id_clear  = 1'b1;
                    id_ex_clear  = 1'b1;
                    ex_mem_clear = 1'b1;
                end
                CAUSE_MEM_BUSY: begin
                    pc_hold      = 1'b1;
                    if_id_hold   = 1'b1;
                    id_ex_hold   = 1'b1;
                    ex_mem_hold  = 1'b1;
                    mem_wb_clear = 1'b1;
                end
                CAUSE_EX_BUSY: begin
                    pc_hold      = 1'b1;
                    if_id_hold   = 1'b1;
                    id_ex_hold   = 1'b1;
                    ex_mem_clear = 1'b1;
                end
                CAUSE_REDIRECT: begin
                    pc_load      = 1'b1;
                    pc_next      = ex_target;
                    if_id_clear  = 1'b1;
                    id_ex_clear  = 1'b1;
                end
                CAUSE_LOAD_USE: begin
                    pc_hold      = 1'b1;
                    if_id_hold   = 1'b1;
                    id_ex_clear  = 1'b1;
                end
                CAUSE_FETCH_WAIT: begin
                    pc_hold      = 1'b1;
                    if_id_clear  = 1'b1;
                end
                default: ;
            endcase

            // Fetch-response bookkeeping. A response arriving alongside a
            // flush is stale and dropped immediately; if it has not arrived
            // yet, DRAIN remembers to drop it later.
            if (r_state == ST_DRAIN) begin
                if_rsp_drop = if_rsp_valid;
                if (w_flush)
                    w_next_state = ST_DRAIN;
                else if (if_rsp_valid)
                    w_next_state = ST_RUN;
            end else if (w_flush) begin
                if_rsp_drop = if_rsp_valid;
                if (if_busy && !if_rsp_valid)
                    w_next_state = ST_DRAIN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (pc_hold)
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_ysyx_210238_pipeline_ctrl.sv
// Directed self-checking bench for ysyx_210238_pipeline_ctrl.
module tb_ysyx_210238_pipeline_ctrl;

    localparam int unsigned XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      id_rs1, id_rs2, ex_rd;
    logic            id_rs1_en, id_rs2_en, ex_load;
    logic            ex_busy, mem_busy, if_busy, if_rsp_valid;
    logic            ex_redirect, mem_trap;
    logic [XLEN-1:0] ex_target, trap_vec;
    logic            pc_hold, pc_load;
    logic [XLEN-1:0] pc_next;
    logic            if_id_hold, if_id_clear, id_ex_hold, id_ex_clear;
    logic            ex_mem_hold, ex_mem_clear, mem_wb_hold, mem_wb_clear;
    logic            if_rsp_drop;
    logic [31:0]     stall_cnt;

    int total = 0;
    int bad   = 0;

    ysyx_210238_pipeline_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
        .ex_rd(ex_rd), .ex_load(ex_load),
        .ex_busy(ex_busy), .mem_busy(mem_busy), .if_busy(if_busy), .if_rsp_valid(if_rsp_valid),
        .ex_redirect(ex_redirect), .ex_target(ex_target),
        .mem_trap(mem_trap), .trap_vec(trap_vec),
        .pc_hold(pc_hold), .pc_load(pc_load), .pc_next(pc_next),
        .if_id_hold(if_id_hold), .if_id_clear(if_id_clear),
        .id_ex_hold(id_ex_hold), .id_ex_clear(id_ex_clear),
        .ex_mem_hold(ex_mem_hold), .ex_mem_clear(ex_mem_clear),
        .mem_wb_hold(mem_wb_hold), .mem_wb_clear(mem_wb_clear),
        .if_rsp_drop(if_rsp_drop), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // {pc_hold,pc_load,if_id_hold,if_id_clear,id_ex_hold,id_ex_clear,
    //  ex_mem_hold,ex_mem_clear,mem_wb_hold,mem_wb_clear,if_rsp_drop}
    logic [10:0] ctl;
    assign ctl = {pc_hold, pc_load, if_id_hold, if_id_clear, id_ex_hold, id_ex_clear,
                  ex_mem_hold, ex_mem_clear, mem_wb_hold, mem_wb_clear, if_rsp_drop};

    localparam logic [10:0] C_IDLE   = 11'b00000000000;
    localparam logic [10:0] C_RESET  = 11'b00010101010;
    localparam logic [10:0] C_LU     = 11'b10100100000;
    localparam logic [10:0] C_REDIR  = 11'b01010100000;
    localparam logic [10:0] C_REDIRD = 11'b01010100001;
    localparam logic [10:0] C_FW     = 11'b10010000000;
    localparam logic [10:0] C_FWD    = 11'b10010000001;
    localparam logic [10:0] C_TRAPD  = 11'b01010101001;
    localparam logic [10:0] C_MEMB   = 11'b10101010010;
    localparam logic [10:0] C_EXB    = 11'b10101001000;
    localparam logic [10:0] C_DROP   = 11'b00000000001;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; id_rs1_en = 0; id_rs2_en = 0;
        ex_rd = 0; ex_load = 0; ex_busy = 0; mem_busy = 0;
        if_busy = 0; if_rsp_valid = 0; ex_redirect = 0; mem_trap = 0;
        ex_target = '0; trap_vec = '0;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with noisy inputs: outputs must still be the reset pattern.
        idle_inputs();
        rst = 1; mem_busy = 1; ex_redirect = 1; ex_target = 64'h1234; if_busy = 1;
        #2;
        chk("reset_ctl", ctl, C_RESET);
        chk("reset_pcload", pc_load, 0);
        cyc();
        chk("reset_cnt", stall_cnt, 0);
        cyc();
        rst = 0; idle_inputs();
        #1;
        chk("idle_ctl", ctl, C_IDLE);
        chk("idle_pcnext", pc_next, 0);

        // Load-use on rs1.
        cyc();
        ex_load = 1; ex_rd = 5; id_rs1_en = 1; id_rs1 = 5;
        #1;
        chk("lu_rs1_ctl", ctl, C_LU);
        cyc();
        chk("lu_rs1_cnt", stall_cnt, 1);
        ex_load = 0;
        #1;
        chk("lu_after_ctl", ctl, C_IDLE);
        cyc();
        chk("lu_after_cnt", stall_cnt, 1);

        // ex_rd = 0: no hazard.
        ex_load = 1; ex_rd = 0; id_rs1_en = 1; id_rs1 = 0;
        #1;
        chk("lu_x0_ctl", ctl, C_IDLE);
        cyc();
        // rs2 path, then same values with rs2_en=0.
        idle_inputs();
        ex_load = 1; ex_rd = 7; id_rs2_en = 1; id_rs2 = 7;
        #1;
        chk("lu_rs2_ctl", ctl, C_LU);
        cyc();
        chk("lu_rs2_cnt", stall_cnt, 2);
        id_rs2_en = 0;
        #1;
        chk("lu_rs2_off_ctl", ctl, C_IDLE);
        cyc();

        // Redirect while fetch outstanding -> DRAIN.
        idle_inputs();
        ex_redirect = 1; ex_target = 64'h80000100; if_busy = 1;
        #1;
        chk("redir_ctl", ctl, C_REDIR);
        chk("redir_pcnext", pc_next, 64'h80000100);
        cyc();
        ex_redirect = 0; ex_target = '0;
        #1;
        chk("drain_wait_ctl", ctl, C_FW);
        cyc();
        chk("drain_wait_cnt", stall_cnt, 3);
        if_busy = 0; if_rsp_valid = 1;
        #1;
        chk("drain_drop_ctl", ctl, C_FWD);
        cyc();
        chk("drain_drop_cnt", stall_cnt, 4);
        #1;
        chk("back_run_ctl", ctl, C_IDLE);
        cyc();

        // Trap beats redirect; response in same cycle dropped, stays RUN.
        idle_inputs();
        mem_trap = 1; ex_redirect = 1; trap_vec = 64'h80000000; ex_target = 64'h55;
        if_rsp_valid = 1;
        #1;
        chk("trap_ctl", ctl, C_TRAPD);
        chk("trap_pcnext", pc_next, 64'h80000000);
        cyc();
        mem_trap = 0; ex_redirect = 0;
        #1;
        chk("trap_run_ctl", ctl, C_IDLE);
        cyc();

        // mem_busy 3 cycles, load-use and trap both masked.
        idle_inputs();
        mem_busy = 1; mem_trap = 1; ex_load = 1; ex_rd = 9; id_rs1_en = 1; id_rs1 = 9;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("memb_ctl", ctl, C_MEMB);
            chk("memb_pcload", pc_load, 0);
            cyc();
        end
        chk("memb_cnt", stall_cnt, 7);

        // ex_busy.
        idle_inputs();
        ex_busy = 1; ex_redirect = 1;
        #1;
        chk("exb_ctl", ctl, C_EXB);
        cyc();
        chk("exb_cnt", stall_cnt, 8);

        // Fetch wait in RUN.
        idle_inputs();
        if_busy = 1;
        #1;
        chk("fw_ctl", ctl, C_FW);
        cyc();
        chk("fw_cnt", stall_cnt, 9);

        // Counter wrap.
        idle_inputs();
        #1;
        force dut.r_stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_stall_cnt;
        #1;
        chk("wrap_pre", stall_cnt, 32'hFFFF_FFFF);
        cyc();
        ex_busy = 1;
        #1;
        cyc();
        chk("wrap_cnt", stall_cnt, 0);

        // Redirect taken in DRAIN keeps DRAIN.
        idle_inputs();
        ex_redirect = 1; ex_target = 64'h200; if_busy = 1;
        cyc();
        if_busy = 0; if_rsp_valid = 1; ex_target = 64'h300;
        #1;
        chk("drain_redir_ctl", ctl, C_REDIRD);
        cyc();
        ex_redirect = 0;
        #1;
        chk("drain_kept_ctl", ctl, C_FWD);
        cyc();
        if_rsp_valid = 0;
        #1;
        chk("drain_exit_ctl", ctl, C_IDLE);
        cyc();

        // Reset while in DRAIN.
        idle_inputs();
        ex_redirect = 1; ex_target = 64'h400; if_busy = 1;
        cyc();
        idle_inputs();
        rst = 1; if_busy = 1;
        #1;
        chk("rst_drain_ctl", ctl, C_RESET);
        cyc();
        rst = 0; if_busy = 0;
        #1;
        chk("rst_drain_run_ctl", ctl, C_IDLE);
        chk("rst_drain_cnt", stall_cnt, 0);
        if_rsp_valid = 1;
        #1;
        chk("rst_nodrop", ctl, C_IDLE & ~C_DROP);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
